// File: rtl/ccff_bitstream_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader_if
// Byte stream handshake feeding the configuration-chain loader.
//   s_data  : bitstream byte, bit 7 is shifted into the chain first
//   s_valid : s_data holds a byte
//   s_ready : loader takes the byte on this cycle's rising edge
// Modports: master = byte source, slave = loader.
// ---------------------------------------------------------------------------
interface ccff_bitstream_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
// Feeds the head of the tile-array configuration chain (ccff). Bytes arrive
// over a valid/ready handshake and are shifted out MSB-first, one bit per
// cycle. ccff_shift_en_o gates prog_clk of the chain at the top level, so
// input stalls simply pause the chain and never corrupt bit alignment.
// After CHAIN_LEN bits the loader parks in DONE until the next start.
//
// Ports
//   prog_clk_i      : single clock, rising edge
//   p_reset_i       : synchronous active-high reset
//   start_i         : begin a load (honoured in IDLE/DONE only)
//   s_if            : byte handshake (slave modport)
//   ccff_head_o     : serial bit to the chain head
//   ccff_shift_en_o : chain clock enable, 1 = chain shifts this cycle
//   ccff_tail_i     : chain tail (read only with CCFF_VERIFY_EN)
//   busy_o          : load in progress
//   done_o          : CHAIN_LEN bits shifted, held until next start
//   err_o           : sticky chain-verify error
//
// Optional feature macro: CCFF_VERIFY_EN
//   When defined, the chain tail is checked after every shift: it must read 0
//   until the last shift (chain is zero after reset) and then the first bit
//   of this load. Without it err_o is tied 0 and ccff_tail_i is ignored.
// ---------------------------------------------------------------------------
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 64
) (
  input  logic                    prog_clk_i,
  input  logic                    p_reset_i,
  input  logic                    start_i,
  ccff_bitstream_loader_if.slave  s_if,
  output logic                    ccff_head_o,
  output logic                    ccff_shift_en_o,
  input  logic                    ccff_tail_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       byte_bits_q, byte_bits_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             s_ready_q, s_ready_d;
  logic             head_q, head_d;
  logic             shift_en_q, shift_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_s;
  logic             last_bit_s;
  logic             final_bit_s;
  logic             start_acc_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] next_inc_s;

  // Bits of the next byte that still belong to the chain: a final partial
  // byte only contributes its top CHAIN_LEN%8 bits.
  function automatic logic [3:0] bits_left(input logic [CNT_W-1:0] cnt);
    int rem;
    rem = CHAIN_LEN - int'(cnt);
    if (rem >= 8) begin
      return 4'd8;
    end else begin
      return 4'(rem);
    end
  endfunction

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_bits_d = byte_bits_q;
    shreg_d     = shreg_q;
    start_acc_s = 1'b0;

    cnt_inc_s   = bit_cnt_q + CNT_W'(1);
    last_bit_s  = (byte_bits_q == 4'd1);
    final_bit_s = (cnt_inc_s == CNT_W'(CHAIN_LEN));
    accept_s    = s_if.s_valid & s_ready_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = ST_LOAD;
          bit_cnt_d   = '0;
          start_acc_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          shreg_d     = s_if.s_data;
          byte_bits_d = bits_left(bit_cnt_q);
          state_d     = ST_SHIFT;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        shreg_d     = {shreg_q[6:0], 1'b0};
        bit_cnt_d   = cnt_inc_s;
        byte_bits_d = byte_bits_q - 4'd1;
        if (last_bit_s) begin
          if (final_bit_s) begin
            state_d = ST_DONE;
          end else if (accept_s) begin
            // Next byte taken during the last bit: no bubble in the chain.
            shreg_d     = s_if.s_data;
            byte_bits_d = bits_left(cnt_inc_s);
            state_d     = ST_SHIFT;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are flops loaded from next-state values, so they equal a
    // decode of the current state without any path from s_* to the chain.
    next_inc_s = bit_cnt_d + CNT_W'(1);
    shift_en_d = (state_d == ST_SHIFT);
    s_ready_d  = (state_d == ST_LOAD) ||
                 ((state_d == ST_SHIFT) && (byte_bits_d == 4'd1) &&
                  (next_inc_s != CNT_W'(CHAIN_LEN)));
    if (shift_en_d) begin
      head_d = shreg_d[7];
    end else begin
      head_d = head_q;
    end
    busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge prog_clk_i) begin
    if (p_reset_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      byte_bits_q <= 4'd0;
      shreg_q     <= 8'd0;
      s_ready_q   <= 1'b0;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_bits_q <= byte_bits_d;
      shreg_q     <= shreg_d;
      s_ready_q   <= s_ready_d;
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign s_if.s_ready    = s_ready_q;
  assign ccff_head_o     = head_q;
  assign ccff_shift_en_o = shift_en_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

`ifdef CCFF_VERIFY_EN
  logic first_bit_q, first_bit_d;
  logic chk_vld_q, chk_vld_d;
  logic chk_last_q, chk_last_d;
  logic err_q, err_d;
  logic exp_tail_s;

  // Tail check: the chain is zero after reset, so the tail reads 0 until the
  // last shift, which must bring the first bit of this load out of the tail.
  always_comb begin
    first_bit_d = first_bit_q;
    if ((state_q == ST_SHIFT) && (bit_cnt_q == '0)) begin
      first_bit_d = shreg_q[7];
    end else begin
      first_bit_d = first_bit_q;
    end
    chk_vld_d  = (state_q == ST_SHIFT);
    chk_last_d = (state_q == ST_SHIFT) && final_bit_s;
    exp_tail_s = chk_last_q ? first_bit_q : 1'b0;
    if (start_acc_s) begin
      err_d = 1'b0;
    end else if (chk_vld_q && (ccff_tail_i != exp_tail_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Verify registers.
  always_ff @(posedge prog_clk_i) begin
    if (p_reset_i) begin
      first_bit_q <= 1'b0;
      chk_vld_q   <= 1'b0;
      chk_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      first_bit_q <= first_bit_d;
      chk_vld_q   <= chk_vld_d;
      chk_last_q  <= chk_last_d;
      err_q       <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_tail_s;
  assign unused_tail_s = ccff_tail_i;
  assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_bitstream_loader
// Directed bench for ccff_bitstream_loader with CHAIN_LEN = 20. The driver
// pushes the expected chain bits of every byte it offers into a queue; a
// monitor pops one bit per shift_en cycle and compares it to ccff_head.
// A behavioural chain model with a selectable tail tap feeds ccff_tail.
// ---------------------------------------------------------------------------
module tb_ccff_bitstream_loader;
  localparam int CHAIN_LEN = 20;

  logic clk = 1'b0;
  logic p_reset;
  logic start;
  logic tail;
  logic head;
  logic shift_en;
  logic busy;
  logic done;
  logic err;

  ccff_bitstream_loader_if bus ();

  ccff_bitstream_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
    .prog_clk_i      (clk),
    .p_reset_i       (p_reset),
    .start_i         (start),
    .s_if            (bus),
    .ccff_head_o     (head),
    .ccff_shift_en_o (shift_en),
    .ccff_tail_i     (tail),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  bit   exp_q[$];
  int   shift_cnt = 0;
  int   first_shift_cyc = 0;
  int   last_shift_cyc = 0;
  int   cyc = 0;
  int   tap = CHAIN_LEN - 1;
  logic [CHAIN_LEN-1:0] chain;
  logic prev_head = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Chain model: flops clear on reset and shift when the loader enables them.
  always @(posedge clk) begin
    if (p_reset) chain <= '0;
    else if (shift_en) chain <= {chain[CHAIN_LEN-2:0], head};
  end
  assign tail = chain[tap];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    check({tag, "_head"}, head, 0);
    check({tag, "_shift_en"}, shift_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Offer one byte; nbits = how many of its top bits reach the chain.
  // gap > 0: wait until ready is seen, then hold off gap more cycles.
  task automatic send_byte(input logic [7:0] b, input int nbits, input int gap);
    int t;
    if (gap > 0) begin
      t = 0;
      while (bus.s_ready !== 1'b1 && t < 100) begin tick(); t++; end
      repeat (gap) tick();
    end
    for (int i = 7; i >= 8 - nbits; i--) exp_q.push_back(b[i]);
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    t = 0;
    while (bus.s_ready !== 1'b1 && t < 100) begin tick(); t++; end
    if (bus.s_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL accept_timeout: s_ready stayed %0b for byte %02h", bus.s_ready, b);
    end else begin
      tick();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 200) begin tick(); t++; end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic load_a5_3c_f0(input int gap);
    send_byte(8'hA5, 8, gap);
    send_byte(8'h3C, 8, gap);
    send_byte(8'hF0, 4, gap);
  endtask

  // Monitor: one expected bit per shift cycle; head must hold while loading.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (shift_en === 1'b1) begin
        if (shift_cnt == 0) first_shift_cyc = cyc;
        last_shift_cyc = cyc;
        shift_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_shift: shift_en=1 with no expected bit (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("head_bit", head, e);
        end
      end else if (busy === 1'b1) begin
        check("head_hold", head, prev_head);
      end
      prev_head = head;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    p_reset     = 1'b1;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (3) tick();
    check_all_zero("reset");
    p_reset = 1'b0;
    tick();

    // 1: back-to-back A5 3C F0
    shift_cnt = 0;
    pulse_start();
    check("t1_busy_load", busy, 1);
    check("t1_ready_load", bus.s_ready, 1);
    load_a5_3c_f0(0);
    wait_done("t1");
    check("t1_shift_count", shift_cnt, 20);
    check("t1_contiguous", last_shift_cyc - first_shift_cyc + 1, 20);
    check("t1_done_latency", cyc, last_shift_cyc + 1);
    check("t1_bits_left", exp_q.size(), 0);
    check("t1_busy_done", busy, 0);
    tick();
    check("t1_err", err, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      check("t1_ready_in_done", bus.s_ready, 0);
      tick();
    end
    bus.s_valid = 1'b0;
    check("t1_no_shift_in_done", shift_cnt, 20);

    // 2: same bytes, 3-cycle valid gaps
    shift_cnt = 0;
    pulse_start();
    load_a5_3c_f0(3);
    wait_done("t2");
    check("t2_shift_count", shift_cnt, 20);
    check("t2_span_with_stalls", last_shift_cyc - first_shift_cyc + 1, 26);
    check("t2_bits_left", exp_q.size(), 0);

    // 3: reset after 9 shifts
    shift_cnt = 0;
    pulse_start();
    send_byte(8'hA5, 8, 0);
    send_byte(8'h3C, 8, 0);
    t = 0;
    while (shift_cnt < 9 && t < 100) begin @(negedge clk); #1; t++; end
    p_reset = 1'b1;
    tick();
    check_all_zero("t3_reset");
    p_reset = 1'b0;
    exp_q.delete();
    check("t3_shifts_before_reset", shift_cnt, 9);
    repeat (5) tick();
    check("t3_no_shift_after_reset", shift_cnt, 9);
    check("t3_idle_busy", busy, 0);
    shift_cnt = 0;
    pulse_start();
    load_a5_3c_f0(0);
    wait_done("t3");
    check("t3_shift_count", shift_cnt, 20);

    // 4: start during SHIFT ignored; start in DONE restarts
    shift_cnt = 0;
    pulse_start();
    send_byte(8'hA5, 8, 0);
    pulse_start();
    check("t4_shift_after_start", shift_en, 1);
    check("t4_busy_after_start", busy, 1);
    send_byte(8'h3C, 8, 0);
    send_byte(8'hF0, 4, 0);
    wait_done("t4a");
    check("t4a_shift_count", shift_cnt, 20);
    pulse_start();
    check("t4_done_cleared", done, 0);
    check("t4_busy_restart", busy, 1);
    check("t4_ready_restart", bus.s_ready, 1);
    shift_cnt = 0;
    send_byte(8'h5A, 8, 0);
    send_byte(8'hC3, 8, 0);
    send_byte(8'h0F, 4, 0);
    wait_done("t4b");
    check("t4b_shift_count", shift_cnt, 20);
    check("t4b_bits_left", exp_q.size(), 0);

`ifdef CCFF_VERIFY_EN
    // 5: chain verify with matching and one-short chain
    p_reset = 1'b1;
    tick();
    p_reset = 1'b0;
    tap = CHAIN_LEN - 1;
    shift_cnt = 0;
    pulse_start();
    load_a5_3c_f0(0);
    wait_done("t5a");
    tick();
    check("t5a_err_good_chain", err, 0);
    p_reset = 1'b1;
    tick();
    p_reset = 1'b0;
    tap = CHAIN_LEN - 2;
    shift_cnt = 0;
    pulse_start();
    load_a5_3c_f0(0);
    wait_done("t5b");
    tick();
    check("t5b_err_short_chain", err, 1);
    repeat (3) tick();
    check("t5b_err_sticky", err, 1);
    pulse_start();
    check("t5b_err_cleared", err, 0);
    p_reset = 1'b1;
    tick();
    p_reset = 1'b0;
`else
    check("t5_err_tied", err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
